// File: rtl/aes_tcdm_reqbuf_if.sv
// ----------------------------------------------------------------------------
// aes_tcdm_reqbuf_if
// TCDM-style request/response bundle for MP independent ports. The same
// interface type carries both the engine-side and interconnect-side buses.
//   req     [MP-1:0]        request, driven by master
//   gnt     [MP-1:0]        grant, driven by slave
//   add     [MP-1:0][31:0]  address, driven by master
//   data    [MP-1:0][31:0]  write data, driven by master
//   wen     [MP-1:0]        1 = read, 0 = write, driven by master
//   be      [MP-1:0][3:0]   byte enables, driven by master
//   r_data  [MP-1:0][31:0]  read response data, driven by slave
//   r_valid [MP-1:0]        read response valid, driven by slave
// ----------------------------------------------------------------------------
interface aes_tcdm_reqbuf_if #(
   parameter int MP = 2
);
   logic [MP-1:0]       req;
   logic [MP-1:0]       gnt;
   logic [MP-1:0][31:0] add;
   logic [MP-1:0][31:0] data;
   logic [MP-1:0]       wen;
   logic [MP-1:0][3:0]  be;
   logic [MP-1:0][31:0] r_data;
   logic [MP-1:0]       r_valid;

   modport master (output req, add, data, wen, be,
                   input  gnt, r_data, r_valid);
   modport slave  (input  req, add, data, wen, be,
                   output gnt, r_data, r_valid);
endinterface

// File: rtl/aes_tcdm_reqbuf.sv
// ----------------------------------------------------------------------------
// aes_tcdm_reqbuf
// Per-port request buffer between an engine and a TCDM interconnect. Each
// port queues engine requests in a small FIFO, issues them in order to the
// interconnect, limits outstanding reads to MAX_OUT, and forwards read
// responses back to the engine one cycle later.
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   flush_i  synchronous clear of all request FIFOs
//   eng      engine-side bus (this block is the slave)
//   tcdm     interconnect-side bus (this block is the master)
//   occ_o    per-port FIFO occupancy
//   out_o    per-port outstanding read count
//   busy_o   any FIFO non-empty or any read outstanding
//   err_o    per-port sticky flag: response arrived with nothing outstanding
// ----------------------------------------------------------------------------
module aes_tcdm_reqbuf #(
   parameter  int MP      = 2,
   parameter  int DEPTH   = 4,
   parameter  int MAX_OUT = 8,
   localparam int CW      = $clog2(DEPTH + 1),
   localparam int OW      = $clog2(MAX_OUT + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   aes_tcdm_reqbuf_if.slave      eng,
   aes_tcdm_reqbuf_if.master     tcdm,
   output logic [MP-1:0][CW-1:0] occ_o,
   output logic [MP-1:0][OW-1:0] out_o,
   output logic                  busy_o,
   output logic [MP-1:0]         err_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [31:0] add;
      logic        wen;
      logic [3:0]  be;
      logic [31:0] data;
   } entry_t;

   logic [MP-1:0] port_busy;

   for (genvar p = 0; p < MP; p++) begin : g_port
      entry_t          mem [DEPTH];
      entry_t          head;
      logic [AW-1:0]   wr_ptr, rd_ptr;
      logic [CW-1:0]   occ;
      logic [OW-1:0]   out_cnt;
      logic            err;
      logic            r_valid_q;
      logic [31:0]     r_data_q;
      logic            full, empty, gnt, req, push, pop, rd_issue, rsp_ok;

      assign full  = (occ == CW'(DEPTH));
      assign empty = (occ == '0);
      assign head  = mem[rd_ptr];

      assign gnt   = !full && !flush_i;
      assign push  = eng.req[p] && gnt;
      // A read at the head blocks everything behind it while the outstanding
      // budget is exhausted; writes never consume that budget.
      assign req   = !empty && !(head.wen && (out_cnt == OW'(MAX_OUT)));
      assign pop   = req && tcdm.gnt[p];

      assign rd_issue = pop && head.wen;
      assign rsp_ok   = tcdm.r_valid[p] && (out_cnt != '0);

      // NOTE: the storage array has no reset; only pointers and occupancy
      // define which entries are live, so stale contents are never observed.
      always_ff @(posedge clk_i) begin
         if (push) begin
            mem[wr_ptr] <= '{add: eng.add[p], wen: eng.wen[p],
                             be: eng.be[p], data: eng.data[p]};
         end
      end

      // NOTE: all state here uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
         end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   occ <= occ + CW'(1);
               2'b01:   occ <= occ - CW'(1);
               default: occ <= occ;
            endcase
         end
      end

      // Outstanding count and response path are untouched by flush so that
      // reads already in flight still complete.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            out_cnt   <= '0;
            err       <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
         end else begin
            case ({rd_issue, rsp_ok})
               2'b10:   if (out_cnt != OW'(MAX_OUT)) out_cnt <= out_cnt + OW'(1);
               2'b01:   out_cnt <= out_cnt - OW'(1);
               default: out_cnt <= out_cnt;
            endcase
            if (tcdm.r_valid[p] && (out_cnt == '0)) err <= 1'b1;
            r_valid_q <= tcdm.r_valid[p];
            if (tcdm.r_valid[p]) r_data_q <= tcdm.r_data[p];
         end
      end

      assign eng.gnt[p]     = gnt;
      assign eng.r_valid[p] = r_valid_q;
      assign eng.r_data[p]  = r_data_q;

      assign tcdm.req[p]  = req;
      assign tcdm.add[p]  = head.add;
      assign tcdm.wen[p]  = head.wen;
      assign tcdm.be[p]   = head.be;
      assign tcdm.data[p] = head.data;

      assign occ_o[p]     = occ;
      assign out_o[p]     = out_cnt;
      assign err_o[p]     = err;
      assign port_busy[p] = (occ != '0) || (out_cnt != '0);
   end

   assign busy_o = |port_busy;

endmodule

// File: tb/tb_aes_tcdm_reqbuf.sv
// ----------------------------------------------------------------------------
// tb_aes_tcdm_reqbuf
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based transaction model of each port.
// ----------------------------------------------------------------------------
module tb_aes_tcdm_reqbuf;
   localparam int MP      = 2;
   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;
   localparam int CW      = $clog2(DEPTH + 1);
   localparam int OW      = $clog2(MAX_OUT + 1);

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   always #5 clk = ~clk;

   aes_tcdm_reqbuf_if #(.MP(MP)) eng ();
   aes_tcdm_reqbuf_if #(.MP(MP)) tcdm ();

   logic [MP-1:0][CW-1:0] occ;
   logic [MP-1:0][OW-1:0] outs;
   logic                  busy;
   logic [MP-1:0]         err;

   aes_tcdm_reqbuf #(.MP(MP), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .eng     (eng.slave),
      .tcdm    (tcdm.master),
      .occ_o   (occ),
      .out_o   (outs),
      .busy_o  (busy),
      .err_o   (err)
   );

   typedef struct packed {
      logic [31:0] add;
      logic        wen;
      logic [3:0]  be;
      logic [31:0] data;
   } req_t;

   // Reference model: one request queue plus counters per port.
   req_t        mq [MP][$];
   int          mout [MP];
   bit          merr [MP];
   bit          mrv  [MP];
   logic [31:0] mrd  [MP];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int p = 0; p < MP; p++) begin
         mq[p].delete();
         mout[p] = 0;
         merr[p] = 1'b0;
         mrv[p]  = 1'b0;
         mrd[p]  = '0;
      end
   endtask

   task automatic idle();
      flush        = 1'b0;
      eng.req      = '0;
      eng.add      = '0;
      eng.data     = '0;
      eng.wen      = '0;
      eng.be       = '0;
      tcdm.gnt     = '0;
      tcdm.r_valid = '0;
      tcdm.r_data  = '0;
   endtask

   // One clock cycle: check combinational outputs against the model for the
   // inputs currently driven, advance the model over the edge, then check
   // registered outputs. Entered and left at posedge + 1.
   task automatic tick();
      bit          mg [MP];
      bit          mr [MP];
      bit          push [MP];
      bit          pop [MP];
      bit          exp_busy;
      req_t        nw [MP];
      #1;
      exp_busy = 1'b0;
      for (int p = 0; p < MP; p++) begin
         mg[p] = (mq[p].size() < DEPTH) && !flush;
         mr[p] = (mq[p].size() > 0) && !(mq[p][0].wen && (mout[p] == MAX_OUT));
         check($sformatf("p%0d_eng_gnt", p), 32'(eng.gnt[p]), 32'(mg[p]));
         check($sformatf("p%0d_tcdm_req", p), 32'(tcdm.req[p]), 32'(mr[p]));
         if (mr[p]) begin
            check($sformatf("p%0d_tcdm_add", p), tcdm.add[p], mq[p][0].add);
            check($sformatf("p%0d_tcdm_wen", p), 32'(tcdm.wen[p]), 32'(mq[p][0].wen));
            check($sformatf("p%0d_tcdm_be", p), 32'(tcdm.be[p]), 32'(mq[p][0].be));
            check($sformatf("p%0d_tcdm_data", p), tcdm.data[p], mq[p][0].data);
         end
         push[p] = eng.req[p] && mg[p];
         pop[p]  = mr[p] && tcdm.gnt[p];
         nw[p]   = '{add: eng.add[p], wen: eng.wen[p], be: eng.be[p], data: eng.data[p]};
         if (mq[p].size() > 0 || mout[p] > 0) exp_busy = 1'b1;
      end
      check("busy", 32'(busy), 32'(exp_busy));

      for (int p = 0; p < MP; p++) begin
         int inc = 0;
         if (pop[p] && mq[p][0].wen) inc = 1;
         if (tcdm.r_valid[p]) begin
            if (mout[p] == 0) merr[p] = 1'b1;
            else              mout[p] = mout[p] - 1;
            mrd[p] = tcdm.r_data[p];
         end
         mout[p] = mout[p] + inc;
         mrv[p]  = tcdm.r_valid[p];
         if (flush) mq[p].delete();
         else begin
            if (pop[p])  void'(mq[p].pop_front());
            if (push[p]) mq[p].push_back(nw[p]);
         end
      end

      @(posedge clk);
      #1;
      for (int p = 0; p < MP; p++) begin
         check($sformatf("p%0d_occ", p), 32'(occ[p]), 32'(mq[p].size()));
         check($sformatf("p%0d_out", p), 32'(outs[p]), 32'(mout[p]));
         check($sformatf("p%0d_err", p), 32'(err[p]), 32'(merr[p]));
         check($sformatf("p%0d_r_valid", p), 32'(eng.r_valid[p]), 32'(mrv[p]));
         check($sformatf("p%0d_r_data", p), eng.r_data[p], mrd[p]);
      end
   endtask

   // Grant everything on port p and answer every outstanding read until idle.
   task automatic drain(input int p);
      int guard = 0;
      eng.req[p] = 1'b0;
      while ((mq[p].size() != 0 || mout[p] != 0) && guard < 40) begin
         tcdm.gnt[p]     = 1'b1;
         tcdm.r_valid[p] = (mout[p] > 0);
         tcdm.r_data[p]  = $urandom;
         tick();
         guard++;
      end
      tcdm.gnt[p]     = 1'b0;
      tcdm.r_valid[p] = 1'b0;
      check($sformatf("p%0d_drain_in_budget", p), 32'(guard < 40), 32'd1);
   endtask

   task automatic push_one(input int p, input logic wen, input logic [3:0] be);
      eng.req[p]  = 1'b1;
      eng.wen[p]  = wen;
      eng.be[p]   = be;
      eng.add[p]  = $urandom;
      eng.data[p] = $urandom;
   endtask

   initial begin
      model_reset();
      idle();
      rst_n = 1'b0;

      // Reset state, including grant asserted while in reset.
      repeat (2) @(posedge clk);
      #1;
      check("rst_occ", 32'(occ), 32'd0);
      check("rst_out", 32'(outs), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_r_valid", 32'(eng.r_valid), 32'd0);
      check("rst_r_data", 32'(eng.r_data[0] | eng.r_data[1]), 32'd0);
      check("rst_tcdm_req", 32'(tcdm.req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_eng_gnt", 32'(eng.gnt), 32'h3);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_eng_gnt", 32'(eng.gnt), 32'h3);

      // Back-to-back reads with no grant: FIFO fills at DEPTH.
      for (int i = 0; i < 4; i++) begin
         push_one(0, 1'b1, 4'hF);
         tick();
      end
      check("fill_gnt_low", 32'(eng.gnt[0]), 32'd0);
      push_one(0, 1'b1, 4'hF);
      tick();
      eng.req[0] = 1'b0;
      check("fill_occ0", 32'(occ[0]), 32'd4);
      check("fill_occ1", 32'(occ[1]), 32'd0);
      check("fill_gnt1", 32'(eng.gnt[1]), 32'd1);

      // Outstanding limit: two reads issue, third holds until a response.
      tcdm.gnt[0] = 1'b1;
      repeat (3) tick();
      check("maxout_req_low", 32'(tcdm.req[0]), 32'd0);
      check("maxout_out", 32'(outs[0]), 32'd2);
      tcdm.r_valid[0] = 1'b1;
      tcdm.r_data[0]  = 32'h1234_5678;
      tick();
      tcdm.r_valid[0] = 1'b0;
      check("maxout_reissue", 32'(tcdm.req[0]), 32'd1);
      drain(0);

      // Single read latency.
      push_one(0, 1'b1, 4'hF);
      tick();
      eng.req[0] = 1'b0;
      check("lat_req_t1", 32'(tcdm.req[0]), 32'd1);
      tcdm.gnt[0] = 1'b1;
      tick();
      tcdm.gnt[0] = 1'b0;
      check("lat_out_t2", 32'(outs[0]), 32'd1);
      tick();
      tcdm.r_valid[0] = 1'b1;
      tcdm.r_data[0]  = 32'hDEAD_BEEF;
      tick();
      tcdm.r_valid[0] = 1'b0;
      check("lat_rvalid_t4", 32'(eng.r_valid[0]), 32'd1);
      check("lat_rdata_t4", eng.r_data[0], 32'hDEAD_BEEF);
      check("lat_out_t4", 32'(outs[0]), 32'd0);
      tick();
      check("lat_rdata_hold", eng.r_data[0], 32'hDEAD_BEEF);

      // Write at head issues even with the read budget exhausted.
      push_one(0, 1'b1, 4'hF);
      tick();
      tcdm.gnt[0] = 1'b1;
      push_one(0, 1'b1, 4'hF);
      tick();
      eng.req[0] = 1'b0;
      tick();
      push_one(0, 1'b0, 4'b0011);
      tick();
      eng.req[0] = 1'b0;
      check("wr_out_full", 32'(outs[0]), 32'd2);
      check("wr_req", 32'(tcdm.req[0]), 32'd1);
      check("wr_wen", 32'(tcdm.wen[0]), 32'd0);
      check("wr_be", 32'(tcdm.be[0]), 32'b0011);
      tick();
      drain(0);

      // Flush with queued entries and one read in flight.
      tcdm.gnt[0] = 1'b1;
      push_one(0, 1'b1, 4'hF);
      tick();
      eng.req[0] = 1'b0;
      tick();
      tcdm.gnt[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_one(0, 1'b0, 4'hC);
         tick();
      end
      check("fl_pre_occ", 32'(occ[0]), 32'd3);
      check("fl_pre_out", 32'(outs[0]), 32'd1);
      flush = 1'b1;
      push_one(0, 1'b0, 4'h1);
      tick();
      flush      = 1'b0;
      eng.req[0] = 1'b0;
      check("fl_occ", 32'(occ[0]), 32'd0);
      check("fl_out", 32'(outs[0]), 32'd1);
      tcdm.r_valid[0] = 1'b1;
      tcdm.r_data[0]  = 32'hCAFE_F00D;
      tick();
      check("fl_rsp_valid", 32'(eng.r_valid[0]), 32'd1);
      check("fl_rsp_data", eng.r_data[0], 32'hCAFE_F00D);
      check("fl_err_clear", 32'(err[0]), 32'd0);
      tick();
      tcdm.r_valid[0] = 1'b0;
      check("spurious_err", 32'(err[0]), 32'd1);
      repeat (3) tick();
      check("spurious_err_sticky", 32'(err[0]), 32'd1);
      check("spurious_out", 32'(outs[0]), 32'd0);

      // Randomized traffic on both ports.
      for (int c = 0; c < 400; c++) begin
         flush = ($urandom_range(0, 24) == 0);
         for (int p = 0; p < MP; p++) begin
            eng.req[p]      = $urandom_range(0, 1);
            eng.wen[p]      = $urandom_range(0, 1);
            eng.be[p]       = 4'($urandom);
            eng.add[p]      = $urandom;
            eng.data[p]     = $urandom;
            tcdm.gnt[p]     = $urandom_range(0, 1);
            tcdm.r_valid[p] = ($urandom_range(0, 3) == 0);
            tcdm.r_data[p]  = $urandom;
         end
         tick();
      end
      idle();

      // Asynchronous reset in mid-traffic, then a stale response.
      tcdm.gnt[1] = 1'b1;
      push_one(1, 1'b1, 4'hF);
      tick();
      tick();
      idle();
      #2 rst_n = 1'b0;
      #1;
      check("arst_occ", 32'(occ), 32'd0);
      check("arst_out", 32'(outs), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      check("arst_req", 32'(tcdm.req), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tcdm.r_valid[1] = 1'b1;
      tcdm.r_data[1]  = 32'h0BAD_0BAD;
      tick();
      tcdm.r_valid[1] = 1'b0;
      check("stale_rsp_err1", 32'(err[1]), 32'd1);
      check("stale_rsp_err0", 32'(err[0]), 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
